led_fade_driver: RTL

LED_FADE_DRIVER -- requirements
Module: led_fade_driver

---
 rtl/led_pkg.sv | 31 +++
 rtl/led_fade_ch.sv | 68 ++++++
 rtl/led_fade_driver.sv | 60 ++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared constants, channel state type and level-to-duty mapping for the LED fade driver.
// Define LED_GAMMA_EN to map levels through the gamma table instead of using them directly.
package led_pkg;

  localparam int LED_N      = 8;
  localparam int LEVEL_MAX  = 15;
  localparam int PWM_PERIOD = 15;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RISE = 2'd1,
    ST_ON   = 2'd2,
    ST_FALL = 2'd3
  } ch_state_t;

  localparam logic [3:0] GAMMA_LUT [16] = '{
    4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2,
    4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd10, 4'd12, 4'd15
  };

`ifdef LED_GAMMA_EN
  localparam bit GAMMA_ON = 1'b1;
`else
  localparam bit GAMMA_ON = 1'b0;
`endif

  function automatic logic [3:0] level_to_duty(input logic [3:0] level);
    return GAMMA_ON ? GAMMA_LUT[level] : level;
  endfunction

endpackage

// File: rtl/led_fade_ch.sv
// One LED channel: fade FSM, brightness level and registered PWM compare.
//   state   | meaning
//   ST_OFF  | dark, level held at 0, waiting for pattern bit
//   ST_RISE | level stepping up on each fade tick
//   ST_ON   | fully lit, level held at max
//   ST_FALL | level stepping down on each fade tick
module led_fade_ch
  import led_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_pat,
  input  logic       i_fade_tick,
  input  logic [3:0] i_pwm_cnt,
  output logic       o_led,
  output logic       o_active
);

  localparam logic [3:0] LVL_TOP = 4'(LEVEL_MAX);

  ch_state_t  r_state;
  logic [3:0] r_level;
  logic       r_led;

  // A pattern-driven state change never steps the level in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_OFF;
      r_level <= 4'd0;
      r_led   <= 1'b0;
    end else begin
      r_led <= (i_pwm_cnt < level_to_duty(r_level));
      case (r_state)
        ST_OFF: begin
          if (i_pat) r_state <= ST_RISE;
        end
        ST_RISE: begin
          if (!i_pat) begin
            r_state <= ST_FALL;
          end else if (r_level == LVL_TOP) begin
            r_state <= ST_ON;
          end else if (i_fade_tick) begin
            r_level <= r_level + 4'd1;
            if (r_level == LVL_TOP - 4'd1) r_state <= ST_ON;
          end
        end
        ST_ON: begin
          if (!i_pat) r_state <= ST_FALL;
        end
        ST_FALL: begin
          if (i_pat) begin
            r_state <= ST_RISE;
          end else if (r_level == 4'd0) begin
            r_state <= ST_OFF;
          end else if (i_fade_tick) begin
            r_level <= r_level - 4'd1;
            if (r_level == 4'd1) r_state <= ST_OFF;
          end
        end
        default: r_state <= ST_OFF;
      endcase
    end
  end

  assign o_led    = r_led;
  assign o_active = (r_state == ST_RISE) || (r_state == ST_FALL);

endmodule

// File: rtl/led_fade_driver.sv
// Eight-channel LED fade driver: shared PWM counter and fade prescaler feeding per-channel faders.
// Duty mapping is linear unless LED_GAMMA_EN is defined.
module led_fade_driver
  import led_pkg::*;
#(
  parameter int FADE_DIV = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LED_N-1:0] pattern,
  output logic [LED_N-1:0] led,
  output logic             busy,
  output logic             frame
);

  localparam logic [3:0]  PWM_TOP   = 4'(PWM_PERIOD - 1);
  localparam logic [15:0] PRESC_TOP = 16'(FADE_DIV - 1);

  logic [LED_N-1:0] r_pat;
  logic [3:0]       r_pwm_cnt;
  logic [15:0]      r_presc;
  logic             r_busy;
  logic             r_frame;
  logic             w_fade_tick;
  logic [LED_N-1:0] w_active;

  assign w_fade_tick = (r_presc == PRESC_TOP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pat     <= '0;
      r_pwm_cnt <= 4'd0;
      r_presc   <= 16'd0;
      r_busy    <= 1'b0;
      r_frame   <= 1'b0;
    end else begin
      r_pat     <= pattern;
      r_pwm_cnt <= (r_pwm_cnt == PWM_TOP) ? 4'd0 : r_pwm_cnt + 4'd1;
      r_presc   <= w_fade_tick ? 16'd0 : r_presc + 16'd1;
      r_busy    <= |w_active;
      r_frame   <= (r_pwm_cnt == 4'd0);
    end
  end

  for (genvar g = 0; g < LED_N; g++) begin : g_ch
    led_fade_ch u_ch (
      .clk         (clk),
      .rst         (rst),
      .i_pat       (r_pat[g]),
      .i_fade_tick (w_fade_tick),
      .i_pwm_cnt   (r_pwm_cnt),
      .o_led       (led[g]),
      .o_active    (w_active[g])
    );
  end

  assign busy  = r_busy;
  assign frame = r_frame;

endmodule
